count_sequence_checker: RTL and testbench
=========================================

Name: count_sequence_checker

Overview:
- Receive-side companion to the 3-bit binary/Gray mode counter.
- Samples the counter's 3-bit code on a strobe and decodes it to binary using the mode input (0 = binary, 1 = Gray).
- Checks that successive samples follow the +1 mod 8 sequence, acquires and holds lock, and reports errors, wraps and a saturating error count.
- Sits in the lab top level between the counter outputs and the LED/7-segment display logic, and is reused as a self-check in benches.

Parameters:
- LOCK_N, 3, consecutive in-sequence samples required to declare lock (1..7).
- LOSS_N, 2, consecutive out-of-sequence samples while locked that drop lock (1..7).
- ERRW, 8, width of ERR_COUNT.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- nRESET  input  1  asynchronous active-low reset.
- SAMPLE  input  1  one-cycle strobe, synchronous to CLOCK: capture CODE this cycle.
- CODE  input  3  counter code (binary or Gray per M).
- M  input  1  code mode: 0 = binary, 1 = Gray; sampled with SAMPLE.
- BIN  output  3  decoded binary value of the last sample.
- VALID  output  1  one-cycle pulse: BIN, ERR and WRAP updated.
- LOCKED  output  1  level: sequence lock held.
- ERR  output  1  one-cycle pulse, coincident with VALID: a locked sample was out of sequence.
- WRAP  output  1  one-cycle pulse, coincident with VALID: a locked 7 -> 0 transition.
- ERR_COUNT  output  ERRW  saturating count of ERR pulses.

Behaviour:
- Reset (nRESET low, asynchronous, any cycle including mid-acquire):
  - BIN=0, VALID=0, LOCKED=0, ERR=0, WRAP=0, ERR_COUNT=0.
  - FSM = SEARCH; match/miss counters = 0; prev = 0; lock_mode = 0.
- Decode (combinational on CODE and M; registered on SAMPLE):
  - M=0: b = CODE.
  - M=1: b2 = g2; b1 = g2^g1; b0 = b1^g0.
- Latency:
  - SAMPLE high in cycle n -> BIN, VALID, ERR, WRAP, LOCKED and ERR_COUNT reflect that sample after edge n+1.
  - VALID, ERR and WRAP are high for exactly one cycle.
  - SAMPLE asserted on consecutive cycles is legal; each cycle is a separate sample.
  - Without SAMPLE, all state holds and the pulse outputs are 0.
- Sequence check: in_seq = (b == prev + 1 mod 8), using 3-bit wrap arithmetic.
- FSM (evaluated only on SAMPLE):
  - SEARCH:
    - prev <= b; match <= 0; go ACQUIRE.
    - No ERR.
  - ACQUIRE:
    - in_seq: match+1; when match+1 == LOCK_N -> LOCKED, LOCKED=1, lock_mode <= M, miss <= 0.
    - Otherwise match <= 0 and stay in ACQUIRE.
    - prev <= b always.
    - No ERR in this state.
  - LOCKED:
    - M != lock_mode: go SEARCH, LOCKED=0, no ERR, no ERR_COUNT increment.
    - in_seq: miss <= 0; WRAP=1 if prev==7 and b==0.
    - Not in_seq: ERR=1, ERR_COUNT+1 (saturates at all-ones and holds), miss+1; when miss+1 == LOSS_N -> SEARCH, LOCKED=0.
    - prev <= b always, so resynchronisation starts from the latest value.
- LOCKED deasserts in the same cycle as the VALID for the sample that causes loss.
- Counter reset seen mid-sequence (e.g. 4 -> 0) is an ordinary out-of-sequence sample.
- A repeated value (b == prev) is out of sequence.
- ERR_COUNT clears only on nRESET.

Test Plan:
- Binary lock and wrap: reset, M=0, SAMPLE on CODE 0,1,2,3,...,7,0:
  - LOCKED rises on the VALID of the 4th sample (value 3).
  - WRAP pulses on the 7 -> 0 sample.
  - ERR never pulses; ERR_COUNT=0.
- Gray decode: M=1, CODE 000,001,011,010,110,111,101,100,000:
  - BIN = 0,1,2,3,4,5,6,7,0.
  - LOCKED after the 4th sample; WRAP on the last sample.
- Single glitch: locked binary at 5, then CODE 3, 4, 5:
  - ERR pulses once on 3 with ERR_COUNT=1 and LOCKED stays 1.
  - 4 is in sequence (prev=3), miss resets, no further ERR.
- Loss and reacquire: locked, then CODE 2, 6 (two misses):
  - ERR pulses twice; LOCKED falls on the second; ERR_COUNT += 2.
  - CODE 7,0,1,2: FSM enters ACQUIRE on 7, LOCKED returns on 2.
- Mode change and async reset: locked with M=0, then SAMPLE with M=1:
  - LOCKED falls; no ERR.
  - Then assert nRESET low mid-cycle during ACQUIRE: all outputs go to 0 immediately, without waiting for a CLOCK edge.
- Saturation: ERRW=8; force 300 locked mismatches (alternate a good lock and a single glitch) -> ERR_COUNT holds at 255.

Source files
------------

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
//   Receive-side checker for the 3-bit binary/Gray mode counter. It captures
//   CODE on SAMPLE and decodes it to binary according to M. It then checks
//   that successive samples step by +1 mod 8, acquires and holds a sequence
//   lock, and reports errors, wraps and a saturating error count.
//
// Ports
//   CLOCK      in   system clock, rising edge
//   nRESET     in   asynchronous active-low reset
//   SAMPLE     in   one-cycle capture strobe
//   CODE[2:0]  in   counter code (binary or Gray)
//   M          in   code mode: 0 = binary, 1 = Gray
//   BIN[2:0]   out  decoded binary value of the last sample
//   VALID      out  pulse: BIN/ERR/WRAP updated
//   LOCKED     out  level: sequence lock held
//   ERR        out  pulse: locked sample out of sequence
//   WRAP       out  pulse: locked 7 -> 0 transition
//   ERR_COUNT  out  saturating count of ERR pulses
module count_sequence_checker #(
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2,
  parameter int ERRW   = 8
) (
  input  logic            CLOCK,
  input  logic            nRESET,
  input  logic            SAMPLE,
  input  logic [2:0]      CODE,
  input  logic            M,
  output logic [2:0]      BIN,
  output logic            VALID,
  output logic            LOCKED,
  output logic            ERR,
  output logic            WRAP,
  output logic [ERRW-1:0] ERR_COUNT
);

  localparam logic [2:0] LOCK_C = 3'(LOCK_N);
  localparam logic [2:0] LOSS_C = 3'(LOSS_N);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        match_q, match_d;
  logic [2:0]        miss_q, miss_d;
  logic [2:0]        prev_q, prev_d;
  logic              lock_mode_q, lock_mode_d;
  logic [2:0]        bin_q, bin_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;

  logic [2:0]        dec_b;
  logic [2:0]        prev_inc;
  logic [2:0]        match_inc;
  logic [2:0]        miss_inc;
  logic              in_seq;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    if (M) dec_b = {CODE[2], CODE[2] ^ CODE[1], CODE[2] ^ CODE[1] ^ CODE[0]};
    else   dec_b = CODE;
  end

  assign prev_inc  = prev_q + 3'd1;
  assign match_inc = match_q + 3'd1;
  assign miss_inc  = miss_q + 3'd1;
  assign in_seq    = (dec_b == prev_inc);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    miss_d      = miss_q;
    prev_d      = prev_q;
    lock_mode_d = lock_mode_q;
    bin_d       = bin_q;
    err_count_d = err_count_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;

    if (SAMPLE) begin
      valid_d = 1'b1;
      bin_d   = dec_b;
      // Every sample becomes the new reference, so resync starts from it.
      prev_d  = dec_b;
      unique case (state_q)
        S_SEARCH: begin
          match_d = '0;
          state_d = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          if (in_seq) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d     = S_LOCKED;
              lock_mode_d = M;
              miss_d      = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          if (M != lock_mode_q) begin
            // A mode switch is a deliberate reconfiguration, not a sequence error.
            state_d = S_SEARCH;
          end else if (in_seq) begin
            miss_d = '0;
            wrap_d = (prev_q == 3'd7) && (dec_b == 3'd0);
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (miss_inc == LOSS_C) state_d = S_SEARCH;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_SEARCH;
      match_q     <= '0;
      miss_q      <= '0;
      prev_q      <= '0;
      lock_mode_q <= 1'b0;
      bin_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      prev_q      <= prev_d;
      lock_mode_q <= lock_mode_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

  assign BIN       = bin_q;
  assign VALID     = valid_q;
  assign LOCKED    = (state_q == S_LOCKED);
  assign ERR       = err_q;
  assign WRAP      = wrap_q;
  assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Testbench for count_sequence_checker: a behavioural model pushes the
// expected output set per sample into a scoreboard queue, and each test task
// pops and compares once the DUT presents VALID.
module tb_count_sequence_checker;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 2;
  localparam int ERRW   = 8;

  logic            CLOCK;
  logic            nRESET;
  logic            SAMPLE;
  logic [2:0]      CODE;
  logic            M;
  logic [2:0]      BIN;
  logic            VALID;
  logic            LOCKED;
  logic            ERR;
  logic            WRAP;
  logic [ERRW-1:0] ERR_COUNT;

  count_sequence_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERRW(ERRW)) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .SAMPLE(SAMPLE), .CODE(CODE), .M(M),
    .BIN(BIN), .VALID(VALID), .LOCKED(LOCKED), .ERR(ERR), .WRAP(WRAP),
    .ERR_COUNT(ERR_COUNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Packed order: bin, locked, err, wrap, err_count
  typedef logic [ERRW+5:0] exp_t;
  exp_t sb[$];
  exp_t obs;
  exp_t e;
  assign obs = {BIN, LOCKED, ERR, WRAP, ERR_COUNT};

  int passed = 0;
  int total  = 0;

  // Reference model state (0 = search, 1 = acquire, 2 = locked)
  int              m_state;
  int              m_match;
  int              m_miss;
  logic [2:0]      m_prev;
  logic            m_lmode;
  logic [ERRW-1:0] m_cnt;
  logic [2:0]      m_bin;

  task automatic model_reset();
    m_state = 0; m_match = 0; m_miss = 0; m_prev = 3'd0; m_lmode = 1'b0;
    m_cnt = '0; m_bin = 3'd0;
    sb.delete();
  endtask

  // Drives one sample (starting just after a rising edge), updates the model,
  // pushes the expectation and advances to 1 time unit past the next edge.
  task automatic drive_sample(input logic [2:0] code, input logic m);
    logic [2:0] b;
    logic err, wrap;
    b = m ? (code ^ (code >> 1) ^ (code >> 2)) : code;
    err = 1'b0; wrap = 1'b0;
    case (m_state)
      0: begin m_match = 0; m_state = 1; end
      1: begin
        if (b == 3'(m_prev + 3'd1)) begin
          m_match++;
          if (m_match == LOCK_N) begin m_state = 2; m_lmode = m; m_miss = 0; end
        end else m_match = 0;
      end
      default: begin
        if (m != m_lmode) m_state = 0;
        else if (b == 3'(m_prev + 3'd1)) begin
          m_miss = 0;
          wrap = (m_prev == 3'd7) && (b == 3'd0);
        end else begin
          err = 1'b1;
          if (m_cnt != {ERRW{1'b1}}) m_cnt = m_cnt + 1'b1;
          m_miss++;
          if (m_miss == LOSS_N) m_state = 0;
        end
      end
    endcase
    m_prev = b;
    m_bin  = b;
    sb.push_back({b, (m_state == 2), err, wrap, m_cnt});
    SAMPLE = 1'b1; CODE = code; M = m;
    @(posedge CLOCK); #1;
    SAMPLE = 1'b0;
  endtask

  task automatic apply_reset();
    SAMPLE = 1'b0; CODE = 3'd0; M = 1'b0;
    nRESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    nRESET = 1'b1;
    model_reset();
    @(posedge CLOCK); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({VALID, obs} !== '0) $display("FAIL reset_state: got %h want 0", {VALID, obs});
    else passed++;
  endtask

  task automatic test_binary_lock();
    apply_reset();
    for (int unsigned i = 0; i < 9; i++) begin
      drive_sample(3'(i), 1'b0);
      e = sb.pop_front();
      total++;
      if (VALID !== 1'b1 || obs !== e)
        $display("FAIL binary_lock[%0d]: got v=%b %h want v=1 %h", i, VALID, obs, e);
      else passed++;
    end
    total++;
    if (LOCKED !== 1'b1 || ERR_COUNT !== '0)
      $display("FAIL binary_end: got locked=%b cnt=%0d want locked=1 cnt=0", LOCKED, ERR_COUNT);
    else passed++;
  endtask

  task automatic test_gray();
    logic [2:0] g[9];
    g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    apply_reset();
    for (int unsigned i = 0; i < 9; i++) begin
      drive_sample(g[i], 1'b1);
      e = sb.pop_front();
      total++;
      if (VALID !== 1'b1 || obs !== e || BIN !== 3'(i))
        $display("FAIL gray[%0d]: got v=%b %h bin=%0d want v=1 %h bin=%0d",
                 i, VALID, obs, BIN, e, 3'(i));
      else passed++;
    end
  endtask

  task automatic test_glitch_and_loss();
    logic [2:0] seq[13];
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5, 3'd2, 3'd6,
            3'd7, 3'd0};
    apply_reset();
    for (int unsigned i = 0; i < 13; i++) begin
      drive_sample(seq[i], 1'b0);
      e = sb.pop_front();
      total++;
      if (VALID !== 1'b1 || obs !== e)
        $display("FAIL glitch_loss[%0d]: got v=%b %h want v=1 %h", i, VALID, obs, e);
      else passed++;
    end
    // Idle cycle: pulses drop, state holds.
    @(posedge CLOCK); #1;
    total++;
    if (VALID !== 1'b0 || obs !== {m_bin, (m_state == 2), 1'b0, 1'b0, m_cnt})
      $display("FAIL idle_hold: got v=%b %h want v=0 %h", VALID, obs,
               {m_bin, (m_state == 2), 1'b0, 1'b0, m_cnt});
    else passed++;
    for (int unsigned i = 1; i < 3; i++) begin
      drive_sample(3'(i), 1'b0);
      e = sb.pop_front();
      total++;
      if (VALID !== 1'b1 || obs !== e)
        $display("FAIL reacquire[%0d]: got v=%b %h want v=1 %h", i, VALID, obs, e);
      else passed++;
    end
    total++;
    if (LOCKED !== 1'b1 || ERR_COUNT !== 8'd3)
      $display("FAIL loss_end: got locked=%b cnt=%0d want locked=1 cnt=3", LOCKED, ERR_COUNT);
    else passed++;
  endtask

  task automatic test_mode_reset();
    apply_reset();
    for (int unsigned i = 4; i < 9; i++) begin
      drive_sample(3'(i), 1'b0);
      e = sb.pop_front();
    end
    drive_sample(3'd1, 1'b1);  // mode change while locked
    e = sb.pop_front();
    total++;
    if (VALID !== 1'b1 || obs !== e || LOCKED !== 1'b0 || ERR !== 1'b0)
      $display("FAIL mode_change: got v=%b %h want v=1 %h", VALID, obs, e);
    else passed++;
    drive_sample(3'd3, 1'b1);  // search -> acquire
    e = sb.pop_front();
    drive_sample(3'd2, 1'b1);  // acquire, BIN nonzero
    e = sb.pop_front();
    SAMPLE = 1'b1; CODE = 3'd6;
    #3 nRESET = 1'b0;
    #1;
    total++;
    if ({VALID, obs} !== '0)
      $display("FAIL async_reset: got %h want 0", {VALID, obs});
    else passed++;
    SAMPLE = 1'b0;
    @(negedge CLOCK);
    nRESET = 1'b1;
    model_reset();
    @(posedge CLOCK); #1;
  endtask

  task automatic test_saturation();
    logic [2:0] p;
    apply_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      drive_sample(3'(i), 1'b0);
      e = sb.pop_front();
    end
    p = 3'd3;
    for (int unsigned i = 0; i < 300; i++) begin
      drive_sample(3'(p + 3'd3), 1'b0);
      e = sb.pop_front();
      if (i == 0 || i == 254 || i == 255 || i == 299) begin
        total++;
        if (VALID !== 1'b1 || obs !== e)
          $display("FAIL sat_err[%0d]: got v=%b %h want v=1 %h", i, VALID, obs, e);
        else passed++;
      end
      drive_sample(3'(p + 3'd4), 1'b0);
      e = sb.pop_front();
      p = 3'(p + 3'd4);
    end
    total++;
    if (ERR_COUNT !== 8'hFF || LOCKED !== 1'b1)
      $display("FAIL saturation: got cnt=%0d locked=%b want cnt=255 locked=1", ERR_COUNT, LOCKED);
    else passed++;
  endtask

  initial begin
    nRESET = 1'b0; SAMPLE = 1'b0; CODE = 3'd0; M = 1'b0;
    model_reset();
    test_reset();
    test_binary_lock();
    test_gray();
    test_glitch_and_loss();
    test_mode_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
